run_splitter_2: RTL and testbench
=================================

// Module: run_splitter_2
// PURPOSE
//  Producer end of the 2-way merger input protocol. Accepts one tuple stream and deals it into two lanes as alternating sorted runs.
//  Each run is closed by a terminator tuple (key[KEY_WIDTH-1:0]==0). Each lane is a show-ahead FIFO read through a data/empty/read port.
//  Sits upstream of a merger pair: lane 1 feeds the merger's fifo_1 port, lane 2 its fifo_2 port.
// PARAMETERS
//  DATA_WIDTH  64  tuple width; key is the low KEY_WIDTH bits
//  KEY_WIDTH   32  key width; key 0 is reserved as the terminator
//  RUN_LEN     8   data tuples per run before a terminator is forced (>=1)
//  FIFO_DEPTH  16  entries per lane FIFO (power of 2, >=4)
// PORTS
//  i_clk        in   1           clock
//  i_rst_n      in   1           async active-low reset
//  i_data       in   DATA_WIDTH  input tuple
//  i_write      in   1           input tuple valid this cycle (writer may assert 1 cycle after o_ready falls)
//  o_ready      out  1           space available for input
//  i_flush      in   1           close the current partial run now
//  o_data_1     out  DATA_WIDTH  lane-1 head tuple (valid when ~o_empty_1)
//  o_empty_1    out  1           lane-1 FIFO empty
//  i_read_1     in   1           pop lane 1 (consumer samples o_data_1 the same cycle)
//  o_data_2     out  DATA_WIDTH  lane-2 head tuple
//  o_empty_2    out  1           lane-2 FIFO empty
//  i_read_2     in   1           pop lane 2
//  o_overrun    out  1           sticky: a write was dropped because a lane was full
//  o_underrun   out  1           sticky: a read arrived while the lane was empty
// BEHAVIOUR
//  Reset: both FIFOs empty, o_empty_1=o_empty_2=1, o_data_*=0, o_ready=1, lane=1, run count=0, pending terminators cleared, sticky flags=0.
//  Reset is asynchronous and may assert mid-run; partial runs are discarded with no terminator.
//  Lane FIFOs:
//    - show-ahead; read latency 0; write-to-visible latency 1 cycle
//    - each lane has an independent write port, so a data write and a terminator write to different lanes can happen in the same cycle
//  o_ready = (free_1>=3) && (free_2>=3), combinational. The slack absorbs the late write plus one terminator.
//  Run FSM: current lane L in {1,2}, counter cnt (0..RUN_LEN-1), pending-terminator flags pt_1/pt_2.
//    - i_write with nonzero key: push to lane L; cnt++.
//        If cnt reaches RUN_LEN: cnt=0, set pt_L, L toggles.
//    - i_write with key==0: push to lane L as that lane's terminator; cnt=0, L toggles. No extra terminator is added.
//    - pt_X set: next cycle write a 0-tuple to lane X and clear pt_X. This takes priority over nothing; it never collides with a data write to lane X.
//    - i_flush with cnt>0: behaves as the end of a run (set pt_L, cnt=0, L toggles).
//      If i_write is also asserted the same cycle, that tuple is counted first and the run then closes.
//    - i_flush with cnt==0: no effect.
//  Full lane: a data or terminator write to a full FIFO is dropped and sets o_overrun. The FIFO state is unchanged.
//  Empty lane: i_read_X while o_empty_X=1 is ignored and sets o_underrun.
//  Simultaneous read and write on a full lane: the write succeeds because the pop frees the slot. On an empty lane the read underruns and the write lands.
//  Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are derived from the MSB compare.
// CONFIGURATION
//  RUN_SPLIT_CHECK_EN defined:
//    - adds output o_order_err (1 bit, sticky, reset 0)
//    - it sets when a nonzero key is lower than the previous nonzero key in the same run (first tuple of each run exempt)
//    - the offending tuple is still forwarded
//  RUN_SPLIT_CHECK_EN undefined: the o_order_err port and the comparator/key register are absent.
// TESTING
//  T1 RUN_LEN=4, write keys 1..8 back-to-back, readers always pop -> lane1: 1,2,3,4,0; lane2: 5,6,7,8,0. Each terminator appears exactly 1 cycle after its last key.
//  T2 Write keys 5,6, then key 0, then 9 -> lane1: 5,6,0; lane2 gets 9. Exactly one terminator in lane1, no forced extra.
//  T3 Write 3, then i_flush alone, then flush again, then 4 -> lane1: 3,0; second flush no-op; lane2 head 4.
//  T4 Readers stalled, write continuously -> o_ready drops at free<3. One write 1 cycle after the drop is accepted with no o_overrun. Forcing writes beyond that sets o_overrun=1 and the lane contents stay intact.
//  T5 Pulse i_read_2 with lane2 empty -> o_underrun=1 and sticks. Assert i_rst_n=0 mid-run -> all flags 0, both lanes empty immediately (asynchronous).
//  T6 (RUN_SPLIT_CHECK_EN) keys 4,2 in one run -> o_order_err=1. Keys 4,0,2 -> stays 0.

Source files
------------

// File: rtl/run_splitter_2.sv
// Deals one tuple stream into two show-ahead lane FIFOs as alternating runs, each closed by a key==0 terminator.
// Optional key-order checker enabled by defining RUN_SPLIT_CHECK_EN.

module run_splitter_2_lane #(
  parameter int DW    = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty,
  output logic [AW:0]   o_free,
  output logic          o_wr_drop,
  output logic          o_rd_under
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, rd_ok, wr_ok;

  assign o_empty    = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_ok      = i_rd && !o_empty;
  // A pop in the same cycle frees the slot, so a write to a full lane still lands.
  assign wr_ok      = i_wr && (!full || rd_ok);
  assign o_wr_drop  = i_wr && !wr_ok;
  assign o_rd_under = i_rd && o_empty;
  assign o_free     = (AW+1)'(DEPTH) - (wptr - rptr);
  assign o_rdata    = o_empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge i_clk)
    if (wr_ok) mem[wptr[AW-1:0]] <= i_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end
endmodule

module run_splitter_2 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 32,
  parameter int RUN_LEN    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_write,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_data_1,
  output logic                  o_empty_1,
  input  logic                  i_read_1,
  output logic [DATA_WIDTH-1:0] o_data_2,
  output logic                  o_empty_2,
  input  logic                  i_read_2,
  output logic                  o_overrun,
  output logic                  o_underrun
`ifdef RUN_SPLIT_CHECK_EN
  ,
  output logic                  o_order_err
`endif
);
  localparam int NUM_LANES = 2;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = $clog2(RUN_LEN + 1);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_wdata, lane_rdata;
  logic [NUM_LANES-1:0][AW:0]           lane_free;
  logic [NUM_LANES-1:0]                 lane_wr, lane_rd, lane_empty, lane_drop, lane_under, lane_ready;
  logic [NUM_LANES-1:0]                 pt, pt_n;

  logic          lane, lane_n;   // 0 = lane 1, 1 = lane 2
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          close, key_zero;

  assign key_zero = (i_data[KEY_WIDTH-1:0] == '0);
  assign cnt_inc  = cnt + 1'b1;
  assign lane_rd  = {i_read_2, i_read_1};

  always_comb begin
    close  = 1'b0;
    lane_n = lane;
    cnt_n  = cnt;
    if (i_write) begin
      if (key_zero) begin
        cnt_n  = '0;
        lane_n = ~lane;
      end else if (cnt_inc == CW'(RUN_LEN) || i_flush) begin
        close  = 1'b1;
        cnt_n  = '0;
        lane_n = ~lane;
      end else begin
        cnt_n = cnt_inc;
      end
    end else if (i_flush && cnt != '0) begin
      close  = 1'b1;
      cnt_n  = '0;
      lane_n = ~lane;
    end
  end

  // The run FSM toggles lanes on every close, so a pending terminator never shares a lane with a data write.
  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      logic data_hit;
      assign data_hit      = i_write && (lane == 1'(l));
      assign lane_wr[l]    = data_hit || pt[l];
      assign lane_wdata[l] = data_hit ? i_data : '0;
      assign pt_n[l]       = close && (lane == 1'(l));
      assign lane_ready[l] = (lane_free[l] >= (AW+1)'(3));

      run_splitter_2_lane #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_lane (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr       (lane_wr[l]),
        .i_wdata    (lane_wdata[l]),
        .i_rd       (lane_rd[l]),
        .o_rdata    (lane_rdata[l]),
        .o_empty    (lane_empty[l]),
        .o_free     (lane_free[l]),
        .o_wr_drop  (lane_drop[l]),
        .o_rd_under (lane_under[l])
      );
    end
  endgenerate

  assign o_ready   = &lane_ready;
  assign o_data_1  = lane_rdata[0];
  assign o_data_2  = lane_rdata[1];
  assign o_empty_1 = lane_empty[0];
  assign o_empty_2 = lane_empty[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane       <= 1'b0;
      cnt        <= '0;
      pt         <= '0;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      lane <= lane_n;
      cnt  <= cnt_n;
      pt   <= pt_n;
      if (|lane_drop)  o_overrun  <= 1'b1;
      if (|lane_under) o_underrun <= 1'b1;
    end
  end

`ifdef RUN_SPLIT_CHECK_EN
  logic [KEY_WIDTH-1:0] prev_key;

  // cnt==0 marks the first tuple of a run, which has nothing to compare against.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_key    <= '0;
      o_order_err <= 1'b0;
    end else if (i_write && !key_zero) begin
      prev_key <= i_data[KEY_WIDTH-1:0];
      if (cnt != '0 && i_data[KEY_WIDTH-1:0] < prev_key) o_order_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_run_splitter_2.sv
// Randomized and directed bench for run_splitter_2 against a queue-based run model.
module tb_run_splitter_2;
  localparam int DW = 64, KW = 32, RL = 4, DEPTH = 16;

  logic          i_clk, i_rst_n, i_write, i_flush, i_read_1, i_read_2;
  logic [DW-1:0] i_data, o_data_1, o_data_2;
  logic          o_ready, o_empty_1, o_empty_2, o_overrun, o_underrun;
`ifdef RUN_SPLIT_CHECK_EN
  logic          o_order_err;
`endif

  run_splitter_2 #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .RUN_LEN(RL), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_write(i_write), .o_ready(o_ready),
    .i_flush(i_flush), .o_data_1(o_data_1), .o_empty_1(o_empty_1), .i_read_1(i_read_1),
    .o_data_2(o_data_2), .o_empty_2(o_empty_2), .i_read_2(i_read_2),
    .o_overrun(o_overrun), .o_underrun(o_underrun)
`ifdef RUN_SPLIT_CHECK_EN
    , .o_order_err(o_order_err)
`endif
  );

  initial begin i_clk = 0; forever #5 i_clk = ~i_clk; end

  int vectors = 0, errs = 0, cyc = 0;

  // reference model: lane contents as queues, run position, closes awaiting a terminator
  logic [DW-1:0] mq1[$], mq2[$], got1[$], got2[$];
  int            gc1[$], gc2[$];
  bit            ml, mpt1, mpt2, mover, munder, merr;
  int            mcnt;
  logic [KW-1:0] mprev;

  task automatic model_reset();
    mq1.delete(); mq2.delete(); ml = 0; mcnt = 0; mpt1 = 0; mpt2 = 0;
    mover = 0; munder = 0; merr = 0; mprev = '0;
  endtask

  task automatic mpush(input bit ln, input logic [DW-1:0] d);
    if (!ln) begin if (mq1.size() >= DEPTH) mover = 1; else mq1.push_back(d); end
    else     begin if (mq2.size() >= DEPTH) mover = 1; else mq2.push_back(d); end
  endtask

  task automatic mclose();
    if (!ml) mpt1 = 1; else mpt2 = 1;
    mcnt = 0; ml = ~ml;
  endtask

  // Applies one cycle of inputs, records popped words, advances the model.
  task automatic drive(input bit w, input logic [DW-1:0] d, input bit f, input bit r1, input bit r2);
    bit t1, t2;
    i_write = w; i_data = d; i_flush = f; i_read_1 = r1; i_read_2 = r2;
    if (r1 && !o_empty_1) begin got1.push_back(o_data_1); gc1.push_back(cyc); end
    if (r2 && !o_empty_2) begin got2.push_back(o_data_2); gc2.push_back(cyc); end
    if (r1) begin if (mq1.size() == 0) munder = 1; else void'(mq1.pop_front()); end
    if (r2) begin if (mq2.size() == 0) munder = 1; else void'(mq2.pop_front()); end
    t1 = mpt1; t2 = mpt2; mpt1 = 0; mpt2 = 0;
    if (t1) mpush(0, '0);
    if (t2) mpush(1, '0);
    if (w) begin
      mpush(ml, d);
      if (d[KW-1:0] == 0) begin mcnt = 0; ml = ~ml; end
      else begin
        if (mcnt > 0 && d[KW-1:0] < mprev) merr = 1;
        mprev = d[KW-1:0];
        mcnt++;
        if (mcnt == RL || f) mclose();
      end
    end else if (f && mcnt > 0) mclose();
    @(posedge i_clk); #1; cyc++;
    i_write = 0; i_flush = 0; i_read_1 = 0; i_read_2 = 0; i_data = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 0; i_write = 0; i_flush = 0; i_read_1 = 0; i_read_2 = 0; i_data = '0;
    model_reset(); got1.delete(); got2.delete(); gc1.delete(); gc2.delete();
    @(posedge i_clk); #1; i_rst_n = 1;
  endtask

  task automatic drain();
    repeat (3 * DEPTH) drive(0, '0, 0, !o_empty_1, !o_empty_2);
  endtask

  function automatic logic [DW-1:0] mk(input int key);
    return {32'($urandom), 32'(key)};
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++; if (o_empty_1 !== 1'b1 || o_empty_2 !== 1'b1) begin errs++; $display("FAIL reset_empty got %b%b want 11", o_empty_1, o_empty_2); end
    vectors++; if (o_data_1 !== '0 || o_data_2 !== '0) begin errs++; $display("FAIL reset_data got %h %h want 0", o_data_1, o_data_2); end
    vectors++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", o_ready); end
    vectors++; if (o_overrun !== 1'b0 || o_underrun !== 1'b0) begin errs++; $display("FAIL reset_flags got %b%b want 00", o_overrun, o_underrun); end
  endtask

  task automatic test_run_len();
    int e1[5] = '{1, 2, 3, 4, 0};
    int e2[5] = '{5, 6, 7, 8, 0};
    do_reset();
    for (int k = 1; k <= 8; k++) drive(1, mk(k), 0, 1, 1);
    repeat (4) drive(0, '0, 0, !o_empty_1, !o_empty_2);
    vectors++; if (got1.size() != 5 || got2.size() != 5) begin errs++; $display("FAIL t1_count got %0d/%0d want 5/5", got1.size(), got2.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        vectors++; if (got1[i][KW-1:0] !== KW'(e1[i])) begin errs++; $display("FAIL t1_lane1[%0d] got %0d want %0d", i, got1[i][KW-1:0], e1[i]); end
        vectors++; if (got2[i][KW-1:0] !== KW'(e2[i])) begin errs++; $display("FAIL t1_lane2[%0d] got %0d want %0d", i, got2[i][KW-1:0], e2[i]); end
      end
      vectors++; if (gc1[4] != gc1[3] + 1 || gc2[4] != gc2[3] + 1) begin errs++; $display("FAIL t1_term_latency got %0d/%0d want 1/1", gc1[4]-gc1[3], gc2[4]-gc2[3]); end
    end
  endtask

  task automatic test_key_zero();
    do_reset();
    drive(1, mk(5), 0, 0, 0); drive(1, mk(6), 0, 0, 0);
    drive(1, mk(0), 0, 0, 0); drive(1, mk(9), 0, 0, 0);
    repeat (2) drive(0, '0, 0, 0, 0);
    drain();
    vectors++; if (got1.size() != 3 || got1[0][KW-1:0] !== 5 || got1[1][KW-1:0] !== 6 || got1[2][KW-1:0] !== 0)
      begin errs++; $display("FAIL t2_lane1 got n=%0d want 5,6,0", got1.size()); end
    vectors++; if (got2.size() != 1 || got2[0][KW-1:0] !== 9) begin errs++; $display("FAIL t2_lane2 got n=%0d want 9", got2.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, mk(3), 0, 0, 0); drive(0, '0, 1, 0, 0); drive(0, '0, 1, 0, 0);
    drive(1, mk(4), 0, 0, 0);
    repeat (2) drive(0, '0, 0, 0, 0);
    vectors++; if (o_empty_2 !== 1'b0 || o_data_2[KW-1:0] !== 4) begin errs++; $display("FAIL t3_lane2_head got %0d want 4", o_data_2[KW-1:0]); end
    drain();
    vectors++; if (got1.size() != 2 || got1[0][KW-1:0] !== 3 || got1[1][KW-1:0] !== 0)
      begin errs++; $display("FAIL t3_lane1 got n=%0d want 3,0", got1.size()); end
    vectors++; if (got2.size() != 1) begin errs++; $display("FAIL t3_lane2_count got %0d want 1", got2.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] s1[$], s2[$];
    int k = 1;
    bit dropped = 0;
    do_reset();
    for (int n = 0; n < 100; n++) begin
      if (!o_ready) begin dropped = 1; break; end
      drive(1, mk(k), 0, 0, 0); k++;
    end
    vectors++; if (!dropped) begin errs++; $display("FAIL t4_ready_drop got 1 want 0 within 100 cycles"); end
    drive(1, mk(k), 0, 0, 0); k++;
    repeat (2) drive(0, '0, 0, 0, 0);
    vectors++; if (o_overrun !== 1'b0) begin errs++; $display("FAIL t4_late_write got overrun=%b want 0", o_overrun); end
    repeat (40) begin drive(1, mk(k), 0, 0, 0); k++; end
    repeat (2) drive(0, '0, 0, 0, 0);
    vectors++; if (o_overrun !== 1'b1) begin errs++; $display("FAIL t4_overrun got %b want 1", o_overrun); end
    s1 = mq1; s2 = mq2;
    drain();
    vectors++; if (got1 != s1 || got2 != s2) begin errs++; $display("FAIL t4_contents got n=%0d/%0d want n=%0d/%0d", got1.size(), got2.size(), s1.size(), s2.size()); end
  endtask

  task automatic test_underrun_async_reset();
    do_reset();
    drive(0, '0, 0, 0, 1);
    vectors++; if (o_underrun !== 1'b1) begin errs++; $display("FAIL t5_underrun got %b want 1", o_underrun); end
    drive(1, mk(1), 0, 0, 0); drive(1, mk(2), 0, 0, 0); drive(1, mk(3), 0, 0, 0);
    vectors++; if (o_underrun !== 1'b1) begin errs++; $display("FAIL t5_sticky got %b want 1", o_underrun); end
    #2 i_rst_n = 0; #1;
    vectors++; if (o_empty_1 !== 1'b1 || o_empty_2 !== 1'b1 || o_underrun !== 1'b0 || o_overrun !== 1'b0 || o_ready !== 1'b1)
      begin errs++; $display("FAIL t5_async got e=%b%b u=%b o=%b r=%b want 11 0 0 1", o_empty_1, o_empty_2, o_underrun, o_overrun, o_ready); end
    @(posedge i_clk); #1; i_rst_n = 1; model_reset();
  endtask

`ifdef RUN_SPLIT_CHECK_EN
  task automatic test_order();
    do_reset();
    drive(1, mk(4), 0, 0, 0); drive(1, mk(2), 0, 0, 0); drive(0, '0, 0, 0, 0);
    vectors++; if (o_order_err !== 1'b1) begin errs++; $display("FAIL t6_order got %b want 1", o_order_err); end
    do_reset();
    drive(1, mk(4), 0, 0, 0); drive(1, mk(0), 0, 0, 0); drive(1, mk(2), 0, 0, 0); drive(0, '0, 0, 0, 0);
    vectors++; if (o_order_err !== 1'b0) begin errs++; $display("FAIL t6_new_run got %b want 0", o_order_err); end
  endtask
`endif

  task automatic test_random();
    bit w, f, r1, r2;
    int key;
    for (int blk = 0; blk < 5; blk++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        vectors++; if (o_empty_1 !== (mq1.size() == 0) || o_empty_2 !== (mq2.size() == 0))
          begin errs++; $display("FAIL rnd_empty @%0d got %b%b want %b%b", cyc, o_empty_1, o_empty_2, mq1.size() == 0, mq2.size() == 0); end
        if (mq1.size() > 0) begin vectors++; if (o_data_1 !== mq1[0]) begin errs++; $display("FAIL rnd_head1 @%0d got %h want %h", cyc, o_data_1, mq1[0]); end end
        if (mq2.size() > 0) begin vectors++; if (o_data_2 !== mq2[0]) begin errs++; $display("FAIL rnd_head2 @%0d got %h want %h", cyc, o_data_2, mq2[0]); end end
        vectors++; if (o_ready !== (DEPTH - mq1.size() >= 3 && DEPTH - mq2.size() >= 3))
          begin errs++; $display("FAIL rnd_ready @%0d got %b", cyc, o_ready); end
        vectors++; if (o_overrun !== mover || o_underrun !== munder)
          begin errs++; $display("FAIL rnd_flags @%0d got %b%b want %b%b", cyc, o_overrun, o_underrun, mover, munder); end
`ifdef RUN_SPLIT_CHECK_EN
        vectors++; if (o_order_err !== merr) begin errs++; $display("FAIL rnd_order @%0d got %b want %b", cyc, o_order_err, merr); end
`endif
        w  = ($urandom_range(0, 9) < 6);
        f  = ($urandom_range(0, 9) == 0);
        r1 = ($urandom_range(0, 9) < (blk == 2 ? 2 : 6));
        r2 = ($urandom_range(0, 9) < (blk == 2 ? 2 : 6));
        key = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
        drive(w, mk(key), f, r1, r2);
      end
    end
  endtask

  initial begin
    i_rst_n = 0; i_write = 0; i_flush = 0; i_read_1 = 0; i_read_2 = 0; i_data = '0;
    test_reset();
    test_run_len();
    test_key_zero();
    test_flush();
    test_backpressure();
    test_underrun_async_reset();
`ifdef RUN_SPLIT_CHECK_EN
    test_order();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
